// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

    typedef enum logic [2:0] {
        StWait   = 3'd0,
        StStable = 3'd1,
        StStage  = 3'd2,
        StRun    = 3'd3,
        StLost   = 3'd4
    } sup_state_e;

    localparam int unsigned LossCountW = 8;

    // Largest of three timing parameters; sizes the shared cycle counters.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the lock supervisor and its environment.
interface pll_lock_supervisor_if;
    import pll_lock_supervisor_pkg::*;

    logic                  pll_lock;
    logic                  clr_status;
    logic                  periph_rst;
    logic                  core_rst;
    logic                  ready;
    logic                  lock_lost;
    logic [LossCountW-1:0] loss_count;
    logic [2:0]            state;

    modport master (
        output pll_lock, clr_status,
        input  periph_rst, core_rst, ready, lock_lost, loss_count, state
    );

    modport slave (
        input  pll_lock, clr_status,
        output periph_rst, core_rst, ready, lock_lost, loss_count, state
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only sync_q is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: qualifies CCC LOCK, sequences peripheral then core
// reset release, and detects/filters lock loss.
// Optional feature: define PLL_LOCK_LOSS_COUNT_EN to implement the saturating
// loss counter; otherwise loss_count is tied to zero.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY        = 16,
    parameter int unsigned LOSS_FILTER        = 4
) (
    input logic                   clk,
    input logic                   rst,
    pll_lock_supervisor_if.slave  sup
);

    localparam int unsigned MaxParam = max3(LOCK_STABLE_CYCLES, STAGE_DELAY, LOSS_FILTER);
    localparam int unsigned CntW     = $clog2(MaxParam + 1);

    localparam logic [CntW-1:0] LockStable = CntW'(LOCK_STABLE_CYCLES);
    localparam logic [CntW-1:0] StageDelay = CntW'(STAGE_DELAY);
    localparam logic [CntW-1:0] LossFilter = CntW'(LOSS_FILTER);

    sup_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CntW-1:0] filt_q, filt_d, filt_inc;
    logic            lock_s;
    logic            loss_evt;
    logic            periph_rst_q, periph_rst_d;
    logic            core_rst_q, core_rst_d;
    logic            ready_q, ready_d;
    logic            lock_lost_q, lock_lost_d;

    sync_2ff u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d_i (sup.pll_lock),
        .q_o (lock_s)
    );

    // Counters never exceed MaxParam, so +1 always fits in CntW bits.
    assign cnt_inc  = cnt_q + CntW'(1);
    assign filt_inc = filt_q + CntW'(1);

    // Next-state decode: qualification, staged release, loss filtering, holdoff.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        filt_d   = '0;
        loss_evt = 1'b0;
        unique case (state_q)
            StWait: begin
                cnt_d = '0;
                if (lock_s) state_d = StStable;
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else if (cnt_inc == LockStable) begin
                    state_d = StStage;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StStage, StRun: begin
                if (!lock_s) filt_d = filt_inc;
                if (!lock_s && (filt_inc == LossFilter)) begin
                    loss_evt = 1'b1;
                    state_d  = StLost;
                    cnt_d    = '0;
                    filt_d   = '0;
                end else if (state_q == StStage) begin
                    // Stage timing keeps running through short unlock glitches.
                    if (cnt_inc == StageDelay) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StLost: begin
                if (cnt_inc == StageDelay) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StWait;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from next state so resets change on the transition edge, glitch-free.
    always_comb begin
        periph_rst_d = !((state_d == StStage) || (state_d == StRun));
        core_rst_d   = (state_d != StRun);
        ready_d      = (state_d == StRun);
        lock_lost_d  = lock_lost_q;
        if (sup.clr_status) lock_lost_d = 1'b0;
        if (loss_evt)       lock_lost_d = 1'b1;
    end

    // FSM, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWait;
            cnt_q        <= '0;
            filt_q       <= '0;
            periph_rst_q <= 1'b1;
            core_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            filt_q       <= filt_d;
            periph_rst_q <= periph_rst_d;
            core_rst_q   <= core_rst_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [LossCountW-1:0] loss_count_q, loss_count_d;

    // Clear first, then count, so a coincident loss leaves the count at 1.
    always_comb begin
        loss_count_d = loss_count_q;
        if (sup.clr_status) loss_count_d = '0;
        if (loss_evt && (loss_count_d != '1)) loss_count_d = loss_count_d + LossCountW'(1);
    end

    // Saturating loss counter register.
    always_ff @(posedge clk) begin
        if (rst) loss_count_q <= '0;
        else     loss_count_q <= loss_count_d;
    end

    assign sup.loss_count = loss_count_q;
`else
    assign sup.loss_count = '0;
`endif

    assign sup.periph_rst = periph_rst_q;
    assign sup.core_rst   = core_rst_q;
    assign sup.ready      = ready_q;
    assign sup.lock_lost  = lock_lost_q;
    assign sup.state      = state_q;

endmodule
